// File: rtl/tdm_mux_16x1.sv
// ---------------------------------------------------------------------------
// tdm_mux_16x1
//   Time-division 16:1 multiplexer. A 16-bit word and a channel-enable mask are
//   captured on start, then one channel is presented per clock on y. The
//   channel address goes out on s3..s0 in the same cycle, so the outputs can
//   feed a demux_1x16 directly.
//
//   Frame timeline, relative to the accept edge E0:
//     E0       capture d/ch_en, busy rises
//     E1..E16  slot k drives channel k (DESCEND: 15-k)
//     E17      done pulses for one cycle, busy falls
//   A start seen while done is high is accepted, which chains frames.
//
// Parameters
//   IDLE_LEVEL  level driven on y when no enabled channel is presented
//   DESCEND     0: channels 0..15, 1: channels 15..0
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   start        frame request, honoured only in the idle or done cycle
//   d[15:0]      data word, bit k belongs to channel k
//   ch_en[15:0]  channel-enable mask
//   y            serial data
//   s3..s0       channel address of the current y (s3 = MSB)
//   valid        y carries an enabled channel this cycle
//   busy         frame in progress
//   done         one-cycle pulse after the last slot
// ---------------------------------------------------------------------------
module tdm_mux_16x1 #(
    parameter logic IDLE_LEVEL = 1'b0,
    parameter bit   DESCEND    = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] d,
    input  logic [15:0] ch_en,
    output logic        y,
    output logic        s3,
    output logic        s2,
    output logic        s1,
    output logic        s0,
    output logic        valid,
    output logic        busy,
    output logic        done
);

    // FINISH is the cycle in which slot 15 is on the outputs; its closing
    // edge raises done.
    typedef enum logic [1:0] {
        IDLE,
        SEND,
        FINISH,
        DONE
    } state_t;

    localparam logic [3:0] FIRST_CH = DESCEND ? 4'd15 : 4'd0;
    localparam logic [3:0] LAST_CH  = DESCEND ? 4'd0  : 4'd15;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q,   cnt_d;
    logic [15:0] data_q,  data_d;
    logic [15:0] mask_q,  mask_d;
    logic [3:0]  sel_q,   sel_d;
    logic        y_q,     y_d;
    logic        valid_q, valid_d;
    logic        busy_q,  busy_d;
    logic        done_q,  done_d;

    logic accept;

    assign accept = start && ((state_q == IDLE) || (state_q == DONE));

    // State register plus all datapath registers.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling the
        // pre-edge values, so ordering between statements does not matter.
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            mask_q  <= '0;
            sel_q   <= '0;
            y_q     <= IDLE_LEVEL;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
            sel_q   <= sel_d;
            y_q     <= y_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = accept ? SEND : IDLE;
            SEND:    state_d = (cnt_q == LAST_CH) ? FINISH : SEND;
            FINISH:  state_d = DONE;
            DONE:    state_d = accept ? SEND : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath logic.
    always_comb begin
        // NOTE: every target gets a default first so no path leaves a latch.
        cnt_d   = cnt_q;
        data_d  = data_q;
        mask_d  = mask_q;
        sel_d   = sel_q;
        y_d     = IDLE_LEVEL;
        valid_d = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    data_d = d;
                    mask_d = ch_en;
                    cnt_d  = FIRST_CH;
                    busy_d = 1'b1;
                end
            end
            SEND: begin
                sel_d   = cnt_q;
                valid_d = mask_q[cnt_q];
                y_d     = mask_q[cnt_q] ? data_q[cnt_q] : IDLE_LEVEL;
                // Wraps only after the last slot, where the counter is unused
                // until the next accept reloads it.
                cnt_d   = DESCEND ? (cnt_q - 4'd1) : (cnt_q + 4'd1);
            end
            FINISH: begin
                done_d = 1'b1;
                busy_d = 1'b0;
            end
            default: ;
        endcase
    end

    assign y     = y_q;
    assign s3    = sel_q[3];
    assign s2    = sel_q[2];
    assign s1    = sel_q[1];
    assign s0    = sel_q[0];
    assign valid = valid_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule
